ramb_s4_fifo_ctrl: RTL and testbench

- FIFO controller that uses an external X_RAMB16_S4_S4-class dual-port block RAM as its storage; sits directly upstream of the RAM and drives both of its ports.
- Port A is the write port and port B is the read port. The controller adds pointers, occupancy tracking and full/almost-full flags.
- It hides the RAM's one-cycle registered read latency behind a 2-entry output buffer, presented to the consumer as a valid/ready stream.

---
 rtl/ramb_s4_fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_ramb_s4_fifo_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ramb_s4_fifo_ctrl.sv
// FIFO controller around an external dual-port block RAM (port A writes, port B reads).
// A 2-entry output buffer hides the RAM's registered read latency behind a valid/ready stream.
module ramb_s4_fifo_ctrl #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 4,
   parameter int AF_LEVEL = 4032
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              WR_EN,
   input  logic [DATA_W-1:0] DIN,
   output logic              FULL,
   output logic              ALMOST_FULL,
   output logic              OVERFLOW,
   output logic [DATA_W-1:0] DOUT,
   output logic              DOUT_VALID,
   input  logic              DOUT_READY,
   output logic [ADDR_W+1:0] COUNT,
   output logic [ADDR_W-1:0] ADDRA,
   output logic [DATA_W-1:0] DIA,
   output logic              ENA,
   output logic              WEA,
   output logic              SSRA,
   output logic [ADDR_W-1:0] ADDRB,
   output logic              ENB,
   output logic              WEB,
   output logic              SSRB,
   input  logic [DATA_W-1:0] DOB
);

   localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(1) << ADDR_W;
   localparam logic [ADDR_W+1:0] AF_W    = (ADDR_W+2)'(AF_LEVEL);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_ram_count;
   logic              r_pending;
   logic [1:0]        r_buf_cnt;
   logic [DATA_W-1:0] r_buf0;
   logic [DATA_W-1:0] r_buf1;
   logic [ADDR_W+1:0] r_count;
   logic              r_af;
   logic              r_ovf;

   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_issue;
   logic [2:0]        w_occ_next;
   logic [1:0]        w_buf_cnt_next;
   logic [1:0]        w_wr_idx;
   logic [ADDR_W:0]   w_ram_count_next;
   logic [ADDR_W+1:0] w_count_next;

   assign w_full = (r_ram_count == DEPTH_W);
   assign w_push = WR_EN & ~w_full;
   assign w_pop  = (r_buf_cnt != 2'd0) & DOUT_READY;

   // Words that will sit in the buffer next cycle; a new read may only be issued
   // if that leaves room for the word it brings back.
   assign w_occ_next     = {1'b0, r_buf_cnt} + {2'b00, r_pending} - {2'b00, w_pop};
   assign w_issue        = (r_ram_count != '0) & (w_occ_next < 3'd2);
   assign w_buf_cnt_next = w_occ_next[1:0];
   assign w_wr_idx       = r_buf_cnt - {1'b0, w_pop};

   assign w_ram_count_next = r_ram_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_issue);
   assign w_count_next     = (ADDR_W+2)'(w_ram_count_next) + (ADDR_W+2)'(w_issue)
                           + (ADDR_W+2)'(w_buf_cnt_next);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_ram_count <= '0;
         r_pending   <= 1'b0;
         r_buf_cnt   <= 2'd0;
         r_buf0      <= '0;
         r_buf1      <= '0;
         r_count     <= '0;
         r_af        <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_issue)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_ram_count <= w_ram_count_next;
         r_pending   <= w_issue;
         r_buf_cnt   <= w_buf_cnt_next;
         if (w_pop)
            r_buf0 <= r_buf1;
         // Capture lands after any pop shift, so the later assignment wins.
         if (r_pending) begin
            if (w_wr_idx == 2'd0)
               r_buf0 <= DOB;
            else
               r_buf1 <= DOB;
         end
         r_count <= w_count_next;
         r_af    <= (w_count_next >= AF_W);
         r_ovf   <= WR_EN & w_full;
      end
   end

   assign FULL        = w_full;
   assign ALMOST_FULL = r_af;
   assign OVERFLOW    = r_ovf;
   assign DOUT        = r_buf0;
   assign DOUT_VALID  = (r_buf_cnt != 2'd0);
   assign COUNT       = r_count;

   assign ADDRA = r_wr_ptr;
   assign DIA   = DIN;
   assign ENA   = w_push;
   assign WEA   = w_push;
   assign SSRA  = 1'b0;
   assign ADDRB = r_rd_ptr;
   assign ENB   = w_issue;
   assign WEB   = 1'b0;
   assign SSRB  = RST;

endmodule

// File: tb/tb_ramb_s4_fifo_ctrl.sv
// Bench for ramb_s4_fifo_ctrl with a behavioural block RAM; a FIFO queue model
// predicts output order and occupancy, checked by a negedge monitor.
module tb_ramb_s4_fifo_ctrl;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 4;
   localparam int DEPTH  = 16;
   localparam int AF_LVL = 14;

   logic              CLK = 1'b0;
   logic              RST, WR_EN, DOUT_READY;
   logic [DATA_W-1:0] DIN;
   logic              FULL, ALMOST_FULL, OVERFLOW, DOUT_VALID;
   logic [DATA_W-1:0] DOUT, DIA, DOB;
   logic [ADDR_W+1:0] COUNT;
   logic [ADDR_W-1:0] ADDRA, ADDRB;
   logic              ENA, WEA, SSRA, ENB, WEB, SSRB;

   logic [DATA_W-1:0] mem [DEPTH];

   int checks = 0;
   int failures = 0;
   int mcnt = 0;
   bit armed = 0;
   logic [DATA_W-1:0] expq [$];
   bit prev_stall = 0;
   bit prev_rst = 1;
   logic [DATA_W-1:0] prev_dout;

   ramb_s4_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AF_LEVEL(AF_LVL)) dut (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .DIN(DIN), .FULL(FULL),
      .ALMOST_FULL(ALMOST_FULL), .OVERFLOW(OVERFLOW), .DOUT(DOUT),
      .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .COUNT(COUNT),
      .ADDRA(ADDRA), .DIA(DIA), .ENA(ENA), .WEA(WEA), .SSRA(SSRA),
      .ADDRB(ADDRB), .ENB(ENB), .WEB(WEB), .SSRB(SSRB), .DOB(DOB)
   );

   always #5 CLK = ~CLK;

   // Block RAM model: synchronous write on A, registered read on B with sync reset.
   always @(posedge CLK) begin
      if (ENA && WEA) mem[ADDRA] <= DIA;
      if (SSRB) DOB <= '0;
      else if (ENB) DOB <= mem[ADDRB];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: queue of accepted words, capacity DEPTH+2 while the consumer stalls.
   always @(negedge CLK) begin
      if (armed) begin
         bit acc, pop;
         logic [DATA_W-1:0] e;
         chk("count", 32'(COUNT), 32'(mcnt));
         pop = DOUT_VALID && DOUT_READY;
         if (pop) begin
            if (expq.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               e = expq.pop_front();
               chk("dout", 32'(DOUT), 32'(e));
            end
         end
         if (prev_stall && !prev_rst)
            chk("dout_hold", {27'd0, DOUT_VALID, DOUT}, {27'd0, 1'b1, prev_dout});
         acc = WR_EN && (mcnt < DEPTH + 2);
         if (acc) expq.push_back(DIN);
         mcnt = mcnt + int'(acc) - int'(pop);
         if (RST) begin
            expq.delete();
            mcnt = 0;
         end
         prev_stall = DOUT_VALID && !DOUT_READY;
         prev_dout  = DOUT;
         prev_rst   = RST;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      RST = 1; WR_EN = 0; DIN = 0; DOUT_READY = 0;
      tick();
      armed = 1;
      tick(); tick();

      // Test 1: single word latency
      RST = 0; WR_EN = 1; DIN = 4'h5; DOUT_READY = 1;
      @(negedge CLK);
      chk("rst_full", 32'(FULL), 0);
      chk("rst_af", 32'(ALMOST_FULL), 0);
      chk("rst_ovf", 32'(OVERFLOW), 0);
      chk("rst_valid", 32'(DOUT_VALID), 0);
      chk("rst_dout", 32'(DOUT), 0);
      tick(); WR_EN = 0;
      @(negedge CLK);
      chk("t1_enb", 32'(ENB), 1);
      chk("t1_addrb", 32'(ADDRB), 0);
      tick(); @(negedge CLK);
      chk("t1_valid_c2", 32'(DOUT_VALID), 0);
      tick(); @(negedge CLK);
      chk("t1_valid_c3", 32'(DOUT_VALID), 1);
      chk("t1_dout_c3", 32'(DOUT), 32'h5);
      tick(); @(negedge CLK);
      chk("t1_valid_c4", 32'(DOUT_VALID), 0);

      // Test 2: fill to full with consumer stalled
      DOUT_READY = 0;
      for (int i = 0; i < 18; i++) begin
         tick(); WR_EN = 1; DIN = 4'((i < 16) ? i : i - 15);
      end
      tick(); WR_EN = 0;
      @(negedge CLK);
      chk("t2_full", 32'(FULL), 1);
      chk("t2_count", 32'(COUNT), 18);
      chk("t2_af", 32'(ALMOST_FULL), 1);
      tick(); WR_EN = 1; DIN = 4'h7;
      @(negedge CLK);
      chk("t2_ena_blocked", 32'(ENA), 0);
      tick(); WR_EN = 0;
      @(negedge CLK);
      chk("t2_ovf", 32'(OVERFLOW), 1);
      chk("t2_count_hold", 32'(COUNT), 18);
      tick(); @(negedge CLK);
      chk("t2_ovf_pulse", 32'(OVERFLOW), 0);

      // Test 3: drain without bubbles
      for (int i = 0; i < 18; i++) begin
         tick(); DOUT_READY = 1;
         @(negedge CLK);
         chk("t3_valid", 32'(DOUT_VALID), 1);
         if (i == 0) begin
            chk("t3_enb", 32'(ENB), 1);
            chk("t3_full_c0", 32'(FULL), 1);
         end
         if (i == 1) chk("t3_full_c1", 32'(FULL), 0);
      end
      tick(); @(negedge CLK);
      chk("t3_empty", 32'(DOUT_VALID), 0);

      // Test 4: streaming with pointer wrap
      for (int c = 0; c < 40; c++) begin
         tick(); WR_EN = 1; DIN = 4'($urandom);
         @(negedge CLK);
         if (c >= 3) chk("t4_valid", 32'(DOUT_VALID), 1);
         chk("t4_count_le3", 32'(COUNT <= 3), 1);
      end
      tick(); WR_EN = 0;
      repeat (4) tick();

      // Test 5: random traffic with backpressure
      sent = 0;
      for (int c = 0; c < 3000 && sent < 200; c++) begin
         tick();
         DOUT_READY = 1'($urandom % 2);
         if (($urandom % 2 == 1) && mcnt < 10) begin
            WR_EN = 1; DIN = 4'($urandom); sent++;
         end else WR_EN = 0;
      end
      chk("t5_sent", 32'(sent), 200);
      tick(); WR_EN = 0; DOUT_READY = 1;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (expq.size() == 0 && !DOUT_VALID) break;
         tick();
      end
      chk("t5_drain", 32'(expq.size()), 0);

      // Test 6: reset with a read in flight
      tick(); DOUT_READY = 0;
      for (int i = 0; i < 6; i++) begin
         WR_EN = 1; DIN = 4'($urandom); tick();
      end
      WR_EN = 0; tick(); tick();
      DOUT_READY = 1;
      @(negedge CLK);
      chk("t6_enb", 32'(ENB), 1);
      tick(); DOUT_READY = 0; RST = 1;
      @(negedge CLK);
      chk("t6_count_pre", 32'(COUNT), 5);
      tick(); RST = 0; WR_EN = 1; DIN = 4'hA; DOUT_READY = 1;
      @(negedge CLK);
      chk("t6_valid_r", 32'(DOUT_VALID), 0);
      chk("t6_count_r", 32'(COUNT), 0);
      chk("t6_full_r", 32'(FULL), 0);
      tick(); WR_EN = 0;
      @(negedge CLK);
      chk("t6_valid_c1", 32'(DOUT_VALID), 0);
      tick(); @(negedge CLK);
      chk("t6_valid_c2", 32'(DOUT_VALID), 0);
      tick(); @(negedge CLK);
      chk("t6_valid_c3", 32'(DOUT_VALID), 1);
      chk("t6_dout_c3", 32'(DOUT), 32'hA);
      tick(); @(negedge CLK);
      chk("t6_valid_c4", 32'(DOUT_VALID), 0);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
